// File: rtl/aes_128_pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : aes_128_pipe_ctrl_if
// Description : Requester/consumer handshake bundle for aes_128_pipe_ctrl.
//               Input side: valid/ready block offer with state, key and tag.
//               Output side: valid/ready result drain with data and tag.
// Revision    : 1.0 - initial release
// ============================================================================
interface aes_128_pipe_ctrl_if #(
    parameter int TAG_W = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in_state;
    logic [127:0]     in_key;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     out_data;
    logic [TAG_W-1:0] out_tag;

    // Requester / consumer side
    modport master (
        output in_valid, in_state, in_key, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    // Controller side
    modport slave (
        input  in_valid, in_state, in_key, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface
`default_nettype wire

// File: rtl/aes_128_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aes_128_pipe_ctrl
// Description : Flow-control wrapper around a fixed-latency, non-stallable
//               aes_128 pipeline. A shadow shift register tracks valid/tag of
//               each block in the core; results land in an output FIFO.
//               Credits (inflight) keep the FIFO from ever overflowing.
//               Optional macro AES_CTRL_PERF_EN adds saturating perf counters
//               perf_blocks (accepts) and perf_stalls (in_valid & !in_ready).
// Revision    : 1.0 - initial release
// ============================================================================
module aes_128_pipe_ctrl #(
    parameter int LATENCY    = 20,
    parameter int TAG_W      = 4,
    parameter int FIFO_DEPTH = 32
) (
    input  wire logic                              clk,
    input  wire logic                              rst,
    aes_128_pipe_ctrl_if.slave                     bus,
    output logic [127:0]                           core_state,
    output logic [127:0]                           core_key,
    input  wire logic [127:0]                      core_out,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]        inflight
`ifdef AES_CTRL_PERF_EN
    ,
    output logic [31:0]                            perf_blocks,
    output logic [31:0]                            perf_stalls
`endif
);

    localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(FIFO_DEPTH);

    logic                   w_in_ready;
    logic                   w_accept;
    logic                   w_push;
    logic                   w_pop;

    logic [LATENCY-1:0]     r_vld;
    logic [TAG_W-1:0]       r_tag [LATENCY];

    logic [127:0]           r_mem_data [FIFO_DEPTH];
    logic [TAG_W-1:0]       r_mem_tag  [FIFO_DEPTH];
    logic [c_ptr_w-1:0]     r_wr_ptr;
    logic [c_ptr_w-1:0]     r_rd_ptr;
    logic [c_cnt_w-1:0]     r_count;
    logic [c_cnt_w-1:0]     r_inflight;

    // Credit check: every block in the core already owns a FIFO slot.
    assign w_in_ready = !rst && (r_inflight < c_depth);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_push     = r_vld[LATENCY-1];
    assign w_pop      = (r_count != '0) && bus.out_ready;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_count != '0);
    assign bus.out_data  = r_mem_data[r_rd_ptr];
    assign bus.out_tag   = r_mem_tag[r_rd_ptr];
    assign inflight      = r_inflight;

    // Idle cycles drive zeros into the core to keep its inputs quiet.
    assign core_state = w_accept ? bus.in_state : 128'h0;
    assign core_key   = w_accept ? bus.in_key   : 128'h0;

    // Shadow valid pipeline; never stalls, mirrors the core's fixed latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[LATENCY-2:0], w_accept};
        end
    end

    // Shadow tag pipeline; tags are only meaningful where r_vld is set.
    always_ff @(posedge clk) begin
        r_tag[0] <= bus.in_tag;
        for (int i = 1; i < LATENCY; i++) begin
            r_tag[i] <= r_tag[i-1];
        end
    end

    // FIFO storage; write side captures the core result as its block exits.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= core_out;
            r_mem_tag[r_wr_ptr]  <= r_tag[LATENCY-1];
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Credit counter: blocks in the core plus entries held in the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= '0;
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // A push into a full FIFO without a matching pop means the credits are broken.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push && (r_count == c_depth) && !w_pop));

`ifdef AES_CTRL_PERF_EN
    logic [31:0] r_perf_blocks;
    logic [31:0] r_perf_stalls;

    assign perf_blocks = r_perf_blocks;
    assign perf_stalls = r_perf_stalls;

    // Saturating counters of accepted blocks and back-pressured offers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_blocks <= '0;
            r_perf_stalls <= '0;
        end else begin
            if (w_accept && (r_perf_blocks != 32'hFFFF_FFFF))
                r_perf_blocks <= r_perf_blocks + 32'd1;
            if (bus.in_valid && !w_in_ready && (r_perf_stalls != 32'hFFFF_FFFF))
                r_perf_stalls <= r_perf_stalls + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_128_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_128_pipe_ctrl
// Description : Self-checking bench for aes_128_pipe_ctrl with a delay-model
//               core (known-answer for the FIPS-197 vector, XOR otherwise).
//               Covers AES_CTRL_PERF_EN counters when that macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_128_pipe_ctrl;

    localparam int LATENCY    = 20;
    localparam int TAG_W      = 4;
    localparam int FIFO_DEPTH = 32;

    localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KAT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KAT_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] core_state;
    logic [127:0] core_key;
    logic [127:0] core_out;
    logic [5:0]   inflight;
`ifdef AES_CTRL_PERF_EN
    logic [31:0]  perf_blocks;
    logic [31:0]  perf_stalls;
`endif

    aes_128_pipe_ctrl_if #(.TAG_W(TAG_W)) bus ();

    aes_128_pipe_ctrl #(
        .LATENCY    (LATENCY),
        .TAG_W      (TAG_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .core_state (core_state),
        .core_key   (core_key),
        .core_out   (core_out),
        .inflight   (inflight)
`ifdef AES_CTRL_PERF_EN
        ,
        .perf_blocks(perf_blocks),
        .perf_stalls(perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    // Core stand-in: fixed-latency pipeline, known answer for the FIPS vector.
    function automatic logic [127:0] core_fn(input logic [127:0] s, input logic [127:0] k);
        if (s == KAT_PT && k == KAT_KEY) return KAT_CT;
        return s ^ k;
    endfunction

    logic [127:0] pipe [LATENCY];
    always @(posedge clk) begin
        pipe[0] <= core_fn(core_state, core_key);
        for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
    assign core_out = pipe[LATENCY-1];

    // Scoreboard of expected results with the cycle they become visible.
    typedef struct {
        logic [127:0]     data;
        logic [TAG_W-1:0] tag;
        int               ready;
    } exp_t;
    exp_t q[$];

    typedef struct {
        logic [127:0]     state;
        logic [127:0]     key;
        logic [TAG_W-1:0] tag;
        logic [127:0]     exp_data;
    } vec_t;
    vec_t vecs[4];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_inflight = 0;
    int n_acc    = 0;
    int n_pops   = 0;
    int n_stall  = 0;
    int max_infl = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, check against the model, advance one edge.
    task automatic cycle(input logic v, input logic [127:0] s, input logic [127:0] k,
                         input logic [TAG_W-1:0] t, input logic r);
        logic acc, pop, exp_ov;
        bus.in_valid  = v;
        bus.in_state  = s;
        bus.in_key    = k;
        bus.in_tag    = t;
        bus.out_ready = r;
        #1;
        exp_ov = (q.size() > 0) && (cyc >= q[0].ready);
        chk("in_ready", {127'b0, bus.in_ready}, {127'b0, (exp_inflight < FIFO_DEPTH)});
        chk("out_valid", {127'b0, bus.out_valid}, {127'b0, exp_ov});
        acc = v && bus.in_ready;
        pop = bus.out_valid && r;
        if (v && !bus.in_ready) n_stall++;
        if (pop) begin
            if (q.size() == 0) begin
                chk("pop_on_empty_model", 128'd1, 128'd0);
            end else begin
                chk("out_data", bus.out_data, q[0].data);
                chk("out_tag", {124'b0, bus.out_tag}, {124'b0, q[0].tag});
                void'(q.pop_front());
            end
            n_pops++;
        end
        if (acc) begin
            q.push_back('{data: core_fn(s, k), tag: t, ready: cyc + 1 + LATENCY});
            n_acc++;
        end
        exp_inflight = exp_inflight + (acc ? 1 : 0) - (pop ? 1 : 0);
        @(posedge clk);
        cyc++;
        #1;
        chk("inflight", {122'b0, inflight}, 128'(exp_inflight));
        if (int'(inflight) > max_infl) max_infl = int'(inflight);
    endtask

    task automatic idle(input logic r);
        cycle(1'b0, 128'h0, 128'h0, '0, r);
    endtask

    // Reset pulse of one edge; checks outputs right after the reset edge.
    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("in_ready_in_reset", {127'b0, bus.in_ready}, 128'd0);
        @(posedge clk);
        cyc++;
        #1;
        chk("rst_out_valid", {127'b0, bus.out_valid}, 128'd0);
        chk("rst_inflight", {122'b0, inflight}, 128'd0);
        rst = 1'b0;
        q.delete();
        exp_inflight = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int e;
        int a0, p0, s0, seen;
        bit rdy_drop;

        vecs[0] = '{KAT_PT, KAT_KEY, 4'd3, KAT_CT};
        vecs[1] = '{128'h0, 128'h0123456789abcdeffedcba9876543210, 4'd0,
                    128'h0123456789abcdeffedcba9876543210};
        vecs[2] = '{{128{1'b1}}, {128{1'b1}}, 4'd15, 128'h0};
        vecs[3] = '{{16{8'ha5}}, {16{8'h5a}}, 4'd9, {128{1'b1}}};

        bus.in_valid = 1'b0; bus.in_state = '0; bus.in_key = '0;
        bus.in_tag = '0; bus.out_ready = 1'b0;
        @(posedge clk); cyc++;
        do_reset();

        // Single blocks: latency, data and tag at the FIFO head.
        foreach (vecs[i]) begin
            cycle(1'b1, vecs[i].state, vecs[i].key, vecs[i].tag, 1'b0);
            e = 0;
            while (!bus.out_valid && e < 3 * LATENCY) begin
                idle(1'b0);
                e++;
            end
            chk("latency", 128'(e), 128'(LATENCY));
            chk("vec_data", bus.out_data, vecs[i].exp_data);
            chk("vec_tag", {124'b0, bus.out_tag}, {124'b0, vecs[i].tag});
            idle(1'b1);
        end

        // Back-to-back stream with free-running consumer.
        max_infl = 0; rdy_drop = 0; a0 = n_acc;
        for (int i = 0; i < 64; i++) begin
            if (!bus.in_ready) rdy_drop = 1;
            cycle(1'b1, 128'(i) << 64 | 128'(i * 7), 128'h1111, 4'(i), 1'b1);
        end
        chk("stream_accepts", 128'(n_acc - a0), 128'd64);
        chk("stream_ready_drop", {127'b0, rdy_drop}, 128'd0);
        chk("stream_peak", 128'(max_infl), 128'(LATENCY + 1));
        e = 0;
        while (q.size() > 0 && e < 4 * LATENCY) begin idle(1'b1); e++; end
        chk("stream_drained", 128'(q.size()), 128'd0);

        // Back-pressure: consumer stalled, exactly FIFO_DEPTH accepts.
        a0 = n_acc;
        for (int i = 0; i < 40 + LATENCY; i++)
            cycle(1'b1, 128'(n_acc) + 128'h5000, 128'h77, 4'(n_acc), 1'b0);
        chk("full_accepts", 128'(n_acc - a0), 128'(FIFO_DEPTH));
        chk("full_in_ready", {127'b0, bus.in_ready}, 128'd0);
        chk("full_inflight", {122'b0, inflight}, 128'(FIFO_DEPTH));
        p0 = n_pops;
        idle(1'b1);
        chk("ready_after_first_pop", {127'b0, bus.in_ready}, 128'd1);
        e = 0;
        while (q.size() > 0 && e < 2 * FIFO_DEPTH) begin idle(1'b1); e++; end
        chk("full_pops", 128'(n_pops - p0), 128'(FIFO_DEPTH));

        // Full FIFO with toggling consumer: scoreboard over 200 blocks.
        for (int i = 0; i < 60 && bus.in_ready; i++)
            cycle(1'b1, 128'(n_acc) + 128'h9000, 128'hABCD, 4'(n_acc), 1'b0);
        a0 = n_acc; p0 = n_pops; max_infl = 0; e = 0;
        while ((n_acc - a0) < 200 && e < 2000) begin
            cycle(1'b1, 128'(n_acc) + 128'h9000, 128'hABCD, 4'(n_acc), e[0]);
            e++;
        end
        chk("toggle_accepts", 128'(n_acc - a0), 128'd200);
        chk("toggle_max_inflight_ok", {127'b0, (max_infl <= FIFO_DEPTH)}, 128'd1);
        e = 0;
        while (q.size() > 0 && e < 200) begin idle(1'b1); e++; end
        chk("toggle_balance", 128'(n_pops - p0), 128'(n_acc - a0 + FIFO_DEPTH));

        // Reset with blocks in flight: nothing stale may emerge.
        for (int i = 0; i < 10; i++)
            cycle(1'b1, 128'(i) + 128'hDEAD0000, 128'h3, 4'(i), 1'b0);
        chk("pre_reset_inflight", {122'b0, inflight}, 128'd10);
        do_reset();
        seen = 0;
        for (int i = 0; i < 2 * LATENCY; i++) begin
            if (bus.out_valid) seen++;
            idle(1'b1);
        end
        chk("stale_out_valid", 128'(seen), 128'd0);

`ifdef AES_CTRL_PERF_EN
        chk("perf_blocks_rst", {96'b0, perf_blocks}, 128'd0);
        chk("perf_stalls_rst", {96'b0, perf_stalls}, 128'd0);
        s0 = n_stall;
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 128'(i), 128'h1, 4'(i), 1'b1);
        e = 0;
        while (q.size() > 0 && e < 3 * LATENCY) begin idle(1'b1); e++; end
        for (int i = 0; i < FIFO_DEPTH + 7; i++)
            cycle(1'b1, 128'(n_acc), 128'h2, 4'(n_acc), 1'b0);
        chk("perf_blocks", {96'b0, perf_blocks}, 128'(5 + FIFO_DEPTH));
        chk("perf_stalls", {96'b0, perf_stalls}, 128'd7);
        chk("perf_stalls_model", 128'(n_stall - s0), 128'd7);
        do_reset();
        chk("perf_blocks_clr", {96'b0, perf_blocks}, 128'd0);
        chk("perf_stalls_clr", {96'b0, perf_stalls}, 128'd0);
`else
        s0 = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
